// File: rtl/e_exc_reg.sv
// ---------------------------------------------------------------------------
// e_exc_reg -- Decode-to-Execute exception pipeline register.
//
// Holds the exception state that a decode-stage instruction carries into the
// execute stage (valid flag, ExcCode, PC, branch-delay bit) and merges in the
// execute-stage overflow faults (Ov, AdEL, AdES). The E/M exception register
// downstream sees one prioritised ExcCode per instruction.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   stall_e      in   hold all E-stage state this cycle
//   flush_e      in   replace the E-stage entry with a bubble (wins over stall)
//   d_exc_valid  in   decode-stage instruction carries an exception
//   d_exc_code   in   decode-stage ExcCode, ignored when d_exc_valid=0
//   d_pc         in   PC of the decode-stage instruction
//   d_bd         in   decode-stage instruction sits in a branch delay slot
//   e_ov         in   ALU signed overflow for the current E instruction
//   e_is_arith   in   E instruction traps on overflow (add, addi, sub)
//   e_is_load    in   E instruction is a load (address add)
//   e_is_store   in   E instruction is a store (address add)
//   e_exc_valid  out  merged exception present for the E instruction
//   e_exc_code   out  merged ExcCode (0 whenever e_exc_valid=0)
//   e_pc         out  registered PC of the E instruction
//   e_bd         out  registered delay-slot bit
//   e_bubble     out  E entry is a flush/reset bubble
//
// Interface note: there is no handshake. The register advances on every
// rising edge unless stall_e holds it; flush_e overrides stall_e.
// ---------------------------------------------------------------------------
module e_exc_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [4:0]  CODE_ADEL = 5'd4,
    parameter logic [4:0]  CODE_ADES = 5'd5,
    parameter logic [4:0]  CODE_OV   = 5'd12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_e,
    input  logic        flush_e,
    input  logic        d_exc_valid,
    input  logic [6:2]  d_exc_code,
    input  logic [31:0] d_pc,
    input  logic        d_bd,
    input  logic        e_ov,
    input  logic        e_is_arith,
    input  logic        e_is_load,
    input  logic        e_is_store,
    output logic        e_exc_valid,
    output logic [6:2]  e_exc_code,
    output logic [31:0] e_pc,
    output logic        e_bd,
    output logic        e_bubble
);

    // Exception carried in from decode (registered part of the merge).
    logic       rValid;
    logic [6:2] rCode;

    // Priority on each edge: flush > stall > load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rValid   <= 1'b0;
            rCode    <= '0;
            e_pc     <= RESET_PC;
            e_bd     <= 1'b0;
            e_bubble <= 1'b1;
        end else if (flush_e) begin
            // The bubble still takes the decode PC/BD so a later interrupt
            // taken on it reports the correct EPC.
            rValid   <= 1'b0;
            rCode    <= '0;
            e_pc     <= d_pc;
            e_bd     <= d_bd;
            e_bubble <= 1'b1;
        end else if (!stall_e) begin
            rValid   <= d_exc_valid;
            rCode    <= d_exc_valid ? d_exc_code : 5'd0;
            e_pc     <= d_pc;
            e_bd     <= d_bd;
            e_bubble <= 1'b0;
        end
    end

    // Combinational merge, zero latency from the e_* inputs. An exception
    // from an earlier stage always wins; bubbles never fault; overflow with
    // no class bit (addu, addiu) is ignored. Class priority arith > load >
    // store only matters for illegal multi-hot class inputs.
    always_comb begin
        e_exc_valid = 1'b0;
        e_exc_code  = '0;
        if (rValid) begin
            e_exc_valid = 1'b1;
            e_exc_code  = rCode;
        end else if (!e_bubble && e_ov) begin
            if (e_is_arith) begin
                e_exc_valid = 1'b1;
                e_exc_code  = CODE_OV;
            end else if (e_is_load) begin
                e_exc_valid = 1'b1;
                e_exc_code  = CODE_ADEL;
            end else if (e_is_store) begin
                e_exc_valid = 1'b1;
                e_exc_code  = CODE_ADES;
            end
        end
    end

endmodule

// File: tb/tb_e_exc_reg.sv
// ---------------------------------------------------------------------------
// tb_e_exc_reg -- bench for the D/E exception pipeline register.
// Directed vector table for the documented scenarios, hand-written async
// reset sequences, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_e_exc_reg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [4:0]  C_ADEL   = 5'd4;
    localparam logic [4:0]  C_ADES   = 5'd5;
    localparam logic [4:0]  C_OV     = 5'd12;
    localparam logic [4:0]  C_RI     = 5'd10;
    // Fault code by class: 0 none, 1 arith, 2 load, 3 store.
    localparam logic [4:0]  FAULT_CODE [4] = '{5'd0, 5'd12, 5'd4, 5'd5};

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        reset_n;
    logic        stall_e;
    logic        flush_e;
    logic        d_exc_valid;
    logic [6:2]  d_exc_code;
    logic [31:0] d_pc;
    logic        d_bd;
    logic        e_ov;
    logic        e_is_arith;
    logic        e_is_load;
    logic        e_is_store;
    logic        e_exc_valid;
    logic [6:2]  e_exc_code;
    logic [31:0] e_pc;
    logic        e_bd;
    logic        e_bubble;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    e_exc_reg dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .d_exc_valid (d_exc_valid),
        .d_exc_code  (d_exc_code),
        .d_pc        (d_pc),
        .d_bd        (d_bd),
        .e_ov        (e_ov),
        .e_is_arith  (e_is_arith),
        .e_is_load   (e_is_load),
        .e_is_store  (e_is_store),
        .e_exc_valid (e_exc_valid),
        .e_exc_code  (e_exc_code),
        .e_pc        (e_pc),
        .e_bd        (e_bd),
        .e_bubble    (e_bubble)
    );

    // Class bits must be one-hot or zero.
    always @(posedge clk) begin
        if (reset_n === 1'b1)
            assert ($onehot0({e_is_arith, e_is_load, e_is_store}))
                else $error("illegal class combination arith=%b load=%b store=%b",
                            e_is_arith, e_is_load, e_is_store);
    end

    // ---------------- scoreboard ----------------
    // Packed expectation: {valid, code[4:0], pc[31:0], bd, bubble}.
    logic [39:0] expQ[$];
    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h t=%0t", tag, fld, act, exp, $time);
        end
    endtask

    task automatic checkOutputs(input string tag);
        logic [39:0] e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.queue actual=empty expected=entry", tag);
        end else begin
            e = expQ.pop_front();
            cmp(tag, "valid",  {31'd0, e_exc_valid}, {31'd0, e[39]});
            cmp(tag, "code",   {27'd0, e_exc_code},  {27'd0, e[38:34]});
            cmp(tag, "pc",     e_pc,                 e[33:2]);
            cmp(tag, "bd",     {31'd0, e_bd},        {31'd0, e[1]});
            cmp(tag, "bubble", {31'd0, e_bubble},    {31'd0, e[0]});
        end
    endtask

    task automatic pushExp(input logic v, input logic [4:0] c, input logic [31:0] pc,
                           input logic bd, input logic bub);
        expQ.push_back({v, c, pc, bd, bub});
    endtask

    // ---------------- driver ----------------
    task automatic driveIn(input logic st, input logic fl, input logic dv,
                           input logic [4:0] dc, input logic [31:0] pc, input logic bd,
                           input logic ov, input int cls);
        stall_e     = st;
        flush_e     = fl;
        d_exc_valid = dv;
        d_exc_code  = dc;
        d_pc        = pc;
        d_bd        = bd;
        e_ov        = ov;
        e_is_arith  = (cls == 1);
        e_is_load   = (cls == 2);
        e_is_store  = (cls == 3);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st, fl, dv;
        logic [4:0]  dc;
        logic [31:0] pc;
        logic        bd, ov;
        int          cls;
        logic        xv;
        logic [4:0]  xc;
        logic [31:0] xpc;
        logic        xbd, xbub;
    } vec_t;

    vec_t vecTab[$];

    task automatic addVec(input logic st, input logic fl, input logic dv, input logic [4:0] dc,
                          input logic [31:0] pc, input logic bd, input logic ov, input int cls,
                          input logic xv, input logic [4:0] xc, input logic [31:0] xpc,
                          input logic xbd, input logic xbub);
        vec_t v;
        v.st = st; v.fl = fl; v.dv = dv; v.dc = dc; v.pc = pc; v.bd = bd;
        v.ov = ov; v.cls = cls;
        v.xv = xv; v.xc = xc; v.xpc = xpc; v.xbd = xbd; v.xbub = xbub;
        vecTab.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic        mV, mBd, mBub;
    logic [4:0]  mC;
    logic [31:0] mPc;

    function automatic logic [5:0] refMerge(input logic v, input logic [4:0] c, input logic bub,
                                            input logic ov, input int cls);
        if (v) return {1'b1, c};
        if (!bub && ov && cls != 0) return {1'b1, FAULT_CODE[cls]};
        return 6'd0;
    endfunction

    task automatic modelReset();
        mV = 1'b0; mC = 5'd0; mPc = RESET_PC; mBd = 1'b0; mBub = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [5:0]  mm;
        logic        st, fl, dv, bd, ov;
        logic [4:0]  dc;
        logic [31:0] pc;
        int          cls;

        reset_n = 1'b1;
        driveIn(0, 0, 0, 5'd0, 32'd0, 0, 0, 0);

        // Reset asserted mid-cycle: outputs must respond without a clock edge.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 pushExp(0, 5'd0, RESET_PC, 0, 1);
        checkOutputs("rst_async");
        driveIn(0, 0, 0, 5'd0, 32'h0000_3004, 0, 1, 1);
        @(posedge clk); #1;
        pushExp(0, 5'd0, RESET_PC, 0, 1);
        checkOutputs("rst_hold");
        @(negedge clk);
        reset_n = 1'b1;

        //      st fl dv code   pc             bd ov cls   xv xcode  xpc            xbd xbub
        addVec(0, 0, 0, 5'd0,  32'h0000_3004, 0, 0, 0,    0, 5'd0,  32'h0000_3004, 0, 0);
        addVec(0, 0, 1, C_RI,  32'h0000_3010, 1, 1, 1,    1, C_RI,  32'h0000_3010, 1, 0);
        addVec(0, 0, 0, 5'd0,  32'h0000_3014, 0, 1, 1,    1, C_OV,  32'h0000_3014, 0, 0);
        addVec(1, 0, 0, 5'd0,  32'h0000_3018, 1, 1, 2,    1, C_ADEL,32'h0000_3014, 0, 0);
        addVec(1, 0, 0, 5'd0,  32'h0000_3018, 1, 1, 3,    1, C_ADES,32'h0000_3014, 0, 0);
        addVec(1, 0, 0, 5'd0,  32'h0000_3018, 1, 0, 3,    0, 5'd0,  32'h0000_3014, 0, 0);
        addVec(0, 0, 1, C_RI,  32'h0000_3020, 0, 0, 0,    1, C_RI,  32'h0000_3020, 0, 0);
        addVec(1, 0, 0, 5'd0,  32'h0000_3024, 1, 0, 0,    1, C_RI,  32'h0000_3020, 0, 0);
        addVec(1, 0, 0, 5'd0,  32'h0000_3024, 1, 0, 0,    1, C_RI,  32'h0000_3020, 0, 0);
        addVec(1, 0, 0, 5'd0,  32'h0000_3024, 1, 0, 0,    1, C_RI,  32'h0000_3020, 0, 0);
        addVec(1, 1, 1, C_RI,  32'h0000_3030, 1, 1, 1,    0, 5'd0,  32'h0000_3030, 1, 1);
        addVec(0, 0, 1, C_ADEL,32'h0000_3034, 0, 1, 3,    1, C_ADEL,32'h0000_3034, 0, 0);
        addVec(0, 1, 1, C_RI,  32'h0000_3038, 0, 1, 2,    0, 5'd0,  32'h0000_3038, 0, 1);
        addVec(0, 0, 0, 5'd0,  32'h0000_303c, 1, 1, 0,    0, 5'd0,  32'h0000_303c, 1, 0);
        addVec(0, 0, 0, 5'd7,  32'h0000_3040, 0, 0, 0,    0, 5'd0,  32'h0000_3040, 0, 0);
        addVec(0, 0, 0, 5'd0,  32'h0000_3048, 0, 1, 1,    1, C_OV,  32'h0000_3048, 0, 0);

        foreach (vecTab[i]) begin
            @(negedge clk);
            driveIn(vecTab[i].st, vecTab[i].fl, vecTab[i].dv, vecTab[i].dc,
                    vecTab[i].pc, vecTab[i].bd, vecTab[i].ov, vecTab[i].cls);
            @(posedge clk); #1;
            pushExp(vecTab[i].xv, vecTab[i].xc, vecTab[i].xpc, vecTab[i].xbd, vecTab[i].xbub);
            checkOutputs($sformatf("vec%0d", i));
        end

        // Merge reacts to e_* with no clock: drop the class bit on the Ov entry.
        #1 e_is_arith = 1'b0;
        #1 pushExp(0, 5'd0, 32'h0000_3048, 0, 0);
        checkOutputs("comb_noclass");
        e_is_arith = 1'b1;
        #1 pushExp(1, C_OV, 32'h0000_3048, 0, 0);
        checkOutputs("comb_ov");

        // Reset in the middle of a live Ov entry, between edges.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 pushExp(0, 5'd0, RESET_PC, 0, 1);
        checkOutputs("rst_midop");
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            dv  = ($urandom_range(0, 2) == 0);
            dc  = 5'($urandom_range(0, 31));
            pc  = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            bd  = 1'($urandom_range(0, 1));
            ov  = 1'($urandom_range(0, 1));
            cls = $urandom_range(0, 3);
            @(negedge clk);
            driveIn(st, fl, dv, dc, pc, bd, ov, cls);
            if (fl) begin
                mV = 0; mC = 0; mPc = pc; mBd = bd; mBub = 1;
            end else if (!st) begin
                mV = dv; mC = dv ? dc : 5'd0; mPc = pc; mBd = bd; mBub = 0;
            end
            @(posedge clk); #1;
            mm = refMerge(mV, mC, mBub, ov, cls);
            pushExp(mm[5], mm[4:0], mPc, mBd, mBub);
            checkOutputs("rnd_edge");
            // Re-randomize the execute-side inputs within the same cycle.
            ov  = 1'($urandom_range(0, 1));
            cls = $urandom_range(0, 3);
            e_ov       = ov;
            e_is_arith = (cls == 1);
            e_is_load  = (cls == 2);
            e_is_store = (cls == 3);
            #1 mm = refMerge(mV, mC, mBub, ov, cls);
            pushExp(mm[5], mm[4:0], mPc, mBd, mBub);
            checkOutputs("rnd_comb");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_exc_reg.md
Name: e_exc_reg

Overview:
- Decode-to-Execute exception pipeline register.
- Captures the decode-stage exception code, valid flag, PC and branch-delay bit at each clock edge.
- Honours stall and flush from the hazard unit.
- Merges execute-stage overflow faults (arithmetic Ov, load/store address overflow AdEL/AdES) combinationally. The consumer, the E/M exception register, sees one prioritised code per instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value held after reset and carried by reset bubbles.
- CODE_ADEL, 5'd4, load address error code.
- CODE_ADES, 5'd5, store address error code.
- CODE_OV, 5'd12, arithmetic overflow code.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_e  in  1  hold all E-stage state this cycle.
- flush_e  in  1  replace the E-stage entry with a bubble this cycle.
- d_exc_valid  in  1  decode-stage instruction carries an exception.
- d_exc_code  in  [6:2]  decode-stage ExcCode (RI or earlier AdEL); ignored when d_exc_valid=0.
- d_pc  in  32  PC of the decode-stage instruction.
- d_bd  in  1  decode-stage instruction is in a branch delay slot.
- e_ov  in  1  execute-stage ALU signed overflow, combinational, current E instruction.
- e_is_arith  in  1  E instruction traps on overflow (add, addi, sub).
- e_is_load  in  1  E instruction is a load (address add).
- e_is_store  in  1  E instruction is a store (address add).
- e_exc_valid  out  1  merged exception present for the E instruction.
- e_exc_code  out  [6:2]  merged ExcCode.
- e_pc  out  32  registered PC of the E instruction.
- e_bd  out  1  registered delay-slot bit.
- e_bubble  out  1  E entry is a flush/reset bubble.

Behaviour:
- Reset (asynchronous, reset_n=0): r_valid=0, r_code=0, e_pc=RESET_PC, e_bd=0, e_bubble=1. Outputs follow the registers immediately, without waiting for a clock edge.
- Per rising edge, priority is flush_e > stall_e > load.
- flush_e=1: r_valid=0, r_code=0, e_bubble=1, e_pc<=d_pc, e_bd<=d_bd. The bubble keeps the PC/BD of the stalled decode instruction so a later interrupt gets a correct EPC.
- flush_e=0, stall_e=1: all registers hold.
- Otherwise (load): r_valid<=d_exc_valid; r_code<=d_exc_valid ? d_exc_code : 0; e_pc<=d_pc; e_bd<=d_bd; e_bubble<=0.
- flush_e and stall_e both 1: flush wins.
- Merge logic is combinational and has zero latency from the e_* inputs.
  - r_valid=1: output r_code. The earlier-stage fault always wins.
  - r_valid=0, e_bubble=0, e_ov=1 and e_is_arith=1: CODE_OV.
  - Same conditions with e_is_load=1: CODE_ADEL.
  - Same conditions with e_is_store=1: CODE_ADES.
  - None of the above: e_exc_valid=0, e_exc_code=0.
- More than one of e_is_arith/load/store set is illegal. Priority is arith > load > store; the bench flags it as an assertion.
- Bubbles never raise an exception, whatever e_ov says.
- e_ov with no class bit set (addu, addiu) gives no exception.
- e_exc_code is 0 whenever e_exc_valid=0.

Test Plan:
- Reset then release: reset_n low mid-cycle -> outputs immediately read valid=0, code=0, pc=0x3000, bubble=1, bd=0. First load edge with d_pc=0x3004 -> e_pc=0x3004, bubble=0.
- RI pass-through: d_exc_valid=1, d_exc_code=10, d_pc=0x3010, d_bd=1, one edge -> e_exc_valid=1, code=10, pc=0x3010, bd=1. e_ov=1 with e_is_arith=1 at the same time still shows code 10.
- Overflow merge: clean add loaded, then e_ov=1, e_is_arith=1 -> code 12. Switch to e_is_load=1 -> 4. Switch to e_is_store=1 -> 5. With e_ov=0 -> valid=0, code=0.
- Stall hold: load an RI entry at 0x3020, then stall_e=1 for 3 edges while d_pc advances to 0x3024 -> e_pc stays 0x3020 and code stays 10 throughout.
- Flush vs stall: stall_e=1 and flush_e=1 together, d_pc=0x3030, d_bd=1 -> bubble=1, valid=0, pc=0x3030, bd=1. e_ov=1 with e_is_arith=1 while bubble=1 -> valid stays 0.
- Reset mid-operation: valid Ov entry present, assert reset_n=0 between edges -> outputs return to reset values at once, with no clock needed.
